// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES block to UART byte path.
package aes_uart_pkg;

  localparam int BLOCK_W     = 128;
  localparam int BYTE_W      = 8;
  localparam int BLOCK_BYTES = 16;

  localparam logic [BYTE_W-1:0] CR = 8'h0D;
  localparam logic [BYTE_W-1:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // Byte k of a block, byte 0 being the most significant byte.
  function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [3:0]         k);
    return blk[BLOCK_W-1-BYTE_W*int'(k) -: BYTE_W];
  endfunction

endpackage

// File: rtl/aes_block_buf2.sv
// Two-entry block buffer: an active shift register plus one holding register.
// A new block loads into the shift register when it is empty or being freed;
// otherwise it waits in hold, and is dropped (sticky overflow) when both are
// occupied and nothing frees this cycle.
import aes_uart_pkg::*;

module aes_block_buf2 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_valid,
  input  logic               free,
  output logic [BLOCK_W-1:0] shift_data,
  output logic               shift_full,
  output logic               hold_full,
  output logic               overflow
);

  logic [BLOCK_W-1:0] hold_data;

  // Load / promote / drop decisions for the two entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_data <= '0;
      hold_data  <= '0;
      shift_full <= 1'b0;
      hold_full  <= 1'b0;
      overflow   <= 1'b0;
    end else if (in_valid) begin
      if (!shift_full) begin
        shift_data <= in_data;
        shift_full <= 1'b1;
      end else if (free) begin
        // Shift register frees this cycle: promote hold if present and park
        // the new block behind it, otherwise the new block goes straight in.
        if (hold_full) begin
          shift_data <= hold_data;
          hold_data  <= in_data;
        end else begin
          shift_data <= in_data;
        end
      end else if (!hold_full) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (free) begin
      if (hold_full) begin
        shift_data <= hold_data;
        hold_full  <= 1'b0;
      end else begin
        shift_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_block_tx_serializer.sv
// Serialises buffered 128-bit AES blocks into bytes on a valid/ready link.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
// byte_valid, once high, stays high with byte_data stable until that edge.
// Optional macro TX_CRLF_EN appends 0x0D, 0x0A after each block's 16 bytes.
import aes_uart_pkg::*;

module aes_block_tx_serializer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [0:127]       block_data,
  input  logic               block_valid,
  output logic [BYTE_W-1:0]  byte_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               block_done,
  output logic               busy,
  output logic               overflow
);

`ifdef TX_CRLF_EN
  localparam int IDX_W     = 5;
  localparam int NUM_BYTES = BLOCK_BYTES + 2;
`else
  localparam int IDX_W     = 4;
  localparam int NUM_BYTES = BLOCK_BYTES;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [7:0]       GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  tx_state_t          state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [7:0]         gap_cnt, gap_cnt_next;
  logic               done_next;
  logic               free;
  logic [BLOCK_W-1:0] shift_data;
  logic               shift_full;
  logic               hold_full;
  logic [BYTE_W-1:0]  cur_byte;

  aes_block_buf2 u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (block_data),
    .in_valid   (block_valid),
    .free       (free),
    .shift_data (shift_data),
    .shift_full (shift_full),
    .hold_full  (hold_full),
    .overflow   (overflow)
  );

  // State, byte index, gap counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      block_done <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      gap_cnt    <= gap_cnt_next;
      block_done <= done_next;
    end
  end

  // Next-state logic; free tells the buffer the active block is finished.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    gap_cnt_next = gap_cnt;
    done_next    = 1'b0;
    free         = 1'b0;
    case (state)
      IDLE: begin
        if (block_valid) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (byte_ready) begin
          gap_cnt_next = '0;
          if (idx != LAST_IDX) begin
            idx_next   = idx + 1'b1;
            state_next = HAS_GAP ? GAP : SEND;
          end else begin
            done_next = 1'b1;
            free      = 1'b1;
            idx_next  = '0;
            if (hold_full || block_valid) state_next = HAS_GAP ? GAP : SEND;
            else                          state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_next   = SEND;
        else                     gap_cnt_next = gap_cnt + 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte selection from the active block (plus trailer when enabled).
  always_comb begin
`ifdef TX_CRLF_EN
    if (idx == IDX_W'(BLOCK_BYTES))          cur_byte = CR;
    else if (idx == IDX_W'(BLOCK_BYTES + 1)) cur_byte = LF;
    else                                     cur_byte = block_byte(shift_data, idx[3:0]);
`else
    cur_byte = block_byte(shift_data, idx);
`endif
  end

  assign byte_valid = (state == SEND);
  assign byte_data  = byte_valid ? cur_byte : '0;
  assign busy       = shift_full | hold_full | (state == GAP);

endmodule

// File: tb/tb_aes_block_tx_serializer.sv
// Directed bench for aes_block_tx_serializer: a GAP_CYCLES=0 instance for the
// buffering/handshake scenarios and a GAP_CYCLES=2 instance for gap timing.
module tb_aes_block_tx_serializer;
  import aes_uart_pkg::*;

`ifdef TX_CRLF_EN
  localparam int NB = 18;
`else
  localparam int NB = 16;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (no gap)
  logic [0:127] block_data = '0;
  logic         block_valid = 1'b0;
  logic [7:0]   byte_data;
  logic         byte_valid;
  logic         byte_ready = 1'b0;
  logic         block_done, busy, overflow;

  aes_block_tx_serializer #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .block_data(block_data), .block_valid(block_valid),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .block_done(block_done), .busy(busy), .overflow(overflow)
  );

  // gap instance
  logic [0:127] g_block_data = '0;
  logic         g_block_valid = 1'b0;
  logic [7:0]   g_byte_data;
  logic         g_byte_valid;
  logic         g_byte_ready = 1'b0;
  logic         g_block_done, g_busy, g_overflow;

  aes_block_tx_serializer #(.GAP_CYCLES(2)) dut_gap (
    .clk(clk), .rst_n(rst_n), .block_data(g_block_data), .block_valid(g_block_valid),
    .byte_data(g_byte_data), .byte_valid(g_byte_valid), .byte_ready(g_byte_ready),
    .block_done(g_block_done), .busy(g_busy), .overflow(g_overflow)
  );

  // scoreboard state
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] g_exp_q[$];
  int         xfers = 0, dones = 0;
  int         g_xfers = 0, g_dones = 0, g_done_cyc = 0;
  int         g_xfer_cyc[$];
  logic       stall = 1'b0;
  logic [7:0] prev_byte = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bytes: leading byte of the hex constant first, then trailer.
  task automatic push_main(input logic [127:0] b);
    logic [127:0] t;
    t = b;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(t[127:120]);
      t = t << 8;
    end
`ifdef TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic push_gap(input logic [127:0] b);
    logic [127:0] t;
    t = b;
    for (int k = 0; k < 16; k++) begin
      g_exp_q.push_back(t[127:120]);
      t = t << 8;
    end
`ifdef TX_CRLF_EN
    g_exp_q.push_back(8'h0D);
    g_exp_q.push_back(8'h0A);
`endif
  endtask

  // Monitor for the main instance: order, stability while stalled, done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", byte_valid, 1);
          check("stall_data", byte_data, prev_byte);
        end
        if (block_done) dones++;
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL extra_byte: actual %0h required none", byte_data);
          end else begin
            check("byte", byte_data, exp_q.pop_front());
          end
          xfers++;
        end
        stall     = byte_valid && !byte_ready;
        prev_byte = byte_data;
      end
    end
  end

  // Monitor for the gap instance.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (g_block_done) begin
          g_dones++;
          g_done_cyc = cyc;
        end
        if (g_byte_valid && g_byte_ready) begin
          if (g_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL gap_extra_byte: actual %0h required none", g_byte_data);
          end else begin
            check("gap_byte", g_byte_data, g_exp_q.pop_front());
          end
          g_xfer_cyc.push_back(cyc);
          g_xfers++;
        end
      end
    end
  end

  // Driver: one block, ready follows a 4-cycle pattern (left bit first).
  task automatic run_block(input logic [127:0] blk, input logic [3:0] pat, input int exp_cyc);
    int start, d0, i;
    start = xfers;
    d0    = dones;
    i     = 0;
    push_main(blk);
    block_data  = blk;
    block_valid = 1'b1;
    tick();
    block_valid = 1'b0;
    check("first_valid", byte_valid, 1);
    check("first_byte", byte_data, blk[127:120]);
    while (xfers - start < NB && i < 300) begin
      byte_ready = pat[3 - (i % 4)];
      tick();
      i++;
    end
    byte_ready = 1'b0;
    check("cycles", i, exp_cyc);
    check("done_pulse", block_done, 1);
    check("busy_after", busy, 0);
    tick();
    check("done_once", dones - d0, 1);
    check("done_low", block_done, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_xfers(input int start, input int n);
    int i;
    i = 0;
    while (xfers - start < n && i < 300) begin
      tick();
      i++;
    end
    check("xfer_count", xfers - start, n);
  endtask

  typedef struct {
    logic [127:0] blk;
    logic [3:0]   pat;
    int           cyc16;
    int           cyc18;
  } vec_t;

  vec_t vecs[3];

  localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
  localparam logic [127:0] BLK_C = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
  localparam logic [127:0] BLK_D = 128'h5A5A0F0FA5A5F0F01234567890ABCDEF;

  initial begin
    int start, d0, n;
    vecs[0] = '{blk: BLK_A, pat: 4'b1111, cyc16: 16, cyc18: 18};
    vecs[1] = '{blk: BLK_A, pat: 4'b1001, cyc16: 32, cyc18: 36};
    vecs[2] = '{blk: BLK_B, pat: 4'b1101, cyc16: 21, cyc18: 24};

    // reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_block_done", block_done, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_gap_valid", g_byte_valid, 0);
    check("rst_gap_busy", g_busy, 0);
    rst_n = 1'b1;
    tick();

    // table-driven single blocks
    for (int v = 0; v < 3; v++) begin
      run_block(vecs[v].blk, vecs[v].pat, (NB == 18) ? vecs[v].cyc18 : vecs[v].cyc16);
    end
    check("no_overflow_yet", overflow, 0);

    // three strobes with ready low: A shifts, B holds, C drops
    start = xfers;
    d0    = dones;
    byte_ready = 1'b0;
    push_main(BLK_A);
    push_main(BLK_B);
    block_valid = 1'b1;
    block_data = BLK_A; tick();
    block_data = BLK_B; tick();
    block_data = BLK_C; tick();
    block_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_busy", busy, 1);
    check("ovf_first_byte", byte_data, 8'h00);
    byte_ready = 1'b1;
    wait_xfers(start, 2 * NB);
    byte_ready = 1'b0;
    tick();
    check("ovf_sticky", overflow, 1);
    check("ovf_dones", dones - d0, 2);
    check("ovf_queue_empty", exp_q.size(), 0);
    check("ovf_busy_after", busy, 0);

    // block_valid coincident with final transfer while hold is full
    do_reset();
    check("rst_clears_ovf", overflow, 0);
    start = xfers;
    d0    = dones;
    push_main(BLK_A);
    push_main(BLK_B);
    block_valid = 1'b1;
    block_data = BLK_A; tick();
    block_data = BLK_B; tick();
    block_valid = 1'b0;
    byte_ready = 1'b1;
    wait_xfers(start, NB - 1);
    check("coinc_last_valid", byte_valid, 1);
    push_main(BLK_D);
    block_data  = BLK_D;
    block_valid = 1'b1;
    tick();
    block_valid = 1'b0;
    check("coinc_no_ovf", overflow, 0);
    check("coinc_done", block_done, 1);
    check("coinc_next_byte", byte_data, BLK_B[127:120]);
    wait_xfers(start, 3 * NB);
    byte_ready = 1'b0;
    tick();
    check("coinc_no_ovf_end", overflow, 0);
    check("coinc_dones", dones - d0, 3);
    check("coinc_queue_empty", exp_q.size(), 0);

    // reset mid-block after byte 5
    start = xfers;
    push_main(BLK_C);
    block_valid = 1'b1;
    block_data = BLK_C; tick();
    block_data = BLK_D; tick();
    block_data = BLK_A; tick();
    block_valid = 1'b0;
    check("mid_ovf_set", overflow, 1);
    byte_ready = 1'b1;
    wait_xfers(start, 6);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    check("mid_rst_valid", byte_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_done", block_done, 0);
    rst_n = 1'b1;
    byte_ready = 1'b0;
    tick();
    run_block(BLK_D, 4'b1111, NB);

    // gap instance: two idle cycles between transfers
    g_xfer_cyc.delete();
    push_gap(BLK_A);
    g_byte_ready  = 1'b1;
    g_block_data  = BLK_A;
    g_block_valid = 1'b1;
    tick();
    g_block_valid = 1'b0;
    check("gap_first_valid", g_byte_valid, 1);
    check("gap_first_byte", g_byte_data, 8'h00);
    tick();
    check("gap_idle_valid", g_byte_valid, 0);
    check("gap_idle_busy", g_busy, 1);
    n = 0;
    while (g_xfers < NB && n < 300) begin
      tick();
      n++;
    end
    tick();
    check("gap_xfer_count", g_xfers, NB);
    for (int k = 1; k < g_xfer_cyc.size(); k++) begin
      check("gap_spacing", g_xfer_cyc[k] - g_xfer_cyc[k-1], 3);
    end
    check("gap_dones", g_dones, 1);
    if (g_xfer_cyc.size() > 0)
      check("gap_done_timing", g_done_cyc, g_xfer_cyc[g_xfer_cyc.size()-1] + 1);
    check("gap_queue_empty", g_exp_q.size(), 0);
    check("gap_busy_after", g_busy, 0);
    check("gap_no_ovf", g_overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
